// File: rtl/da_pkg.sv
// Shared helpers for the distributed-arithmetic MAC engine: width math and
// the frame-sequencing state encoding.
package da_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // {bank, entry} coefficient address width
  function automatic int aw_f(input int nbank, input int k);
    return clog2(nbank) + k;
  endfunction

  // Adder-tree sum width: one growth bit per tree level
  function automatic int sw_f(input int cw, input int nbank);
    return cw + clog2(nbank);
  endfunction

  function automatic int accw_f(input int cw, input int nbank, input int b);
    return cw + clog2(nbank) + b;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_e;

endpackage

// File: rtl/da_lut_bank.sv
// One partial-sum LUT bank: synchronous write port and a registered read port
// so the array maps onto block RAM.
module da_lut_bank #(
  parameter int K  = 8,
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [K-1:0]  waddr_i,
  input  logic [CW-1:0] wdata_i,
  input  logic [K-1:0]  raddr_i,
  output logic [CW-1:0] rdata_o
);

  logic [CW-1:0] mem_q [2**K];
  logic [CW-1:0] rdata_q;

  // Contents are deliberately never reset; tables survive a reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/da_mac_engine.sv
// Distributed-arithmetic MAC: NBANK LUT banks, registered adder tree and a
// shift-accumulator over B bit-planes, sign plane first, with valid/ready I/O.
module da_mac_engine
  import da_pkg::*;
#(
  parameter  int NBANK = 8,
  parameter  int K     = 8,
  parameter  int CW    = 20,
  parameter  int B     = 16,
  localparam int LG    = clog2(NBANK),
  localparam int AW    = aw_f(NBANK, K),
  localparam int SW    = sw_f(CW, NBANK),
  localparam int ACCW  = accw_f(CW, NBANK, B)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cload,
  input  logic [AW-1:0]      caddr,
  input  logic [CW-1:0]      cdata,
  input  logic               plane_valid,
  output logic               plane_ready,
  input  logic [NBANK*K-1:0] plane_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACCW-1:0]    out_data,
  output logic               busy
);

  localparam int CNTW = clog2(B) + 1;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            v1_q, s1_q, l1_q;
  logic            v2_q, s2_q, l2_q;
  logic            l3_q;
  logic [SW-1:0]   sum_d, sum2_q;
  logic [ACCW-1:0] acc_q, out_data_q, sum_ext;
  logic            accept, last_plane, lut_we;
  logic [CW-1:0]   bank_rd [NBANK];

  assign plane_ready = !reset && ((state_q == IDLE && !cload) || state_q == RUN);
  assign accept      = plane_valid && plane_ready;
  assign last_plane  = accept && state_q == RUN && cnt_q == CNTW'(B - 1);
  assign lut_we      = cload && state_q == IDLE && !reset;

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      da_lut_bank #(.K(K), .CW(CW)) u_bank (
        .clk     (clk),
        .we_i    (lut_we && caddr[AW-1:K] == LG'(gi)),
        .waddr_i (caddr[K-1:0]),
        .wdata_i (cdata),
        .raddr_i (plane_addr[gi*K +: K]),
        .rdata_o (bank_rd[gi])
      );
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NBANK; i++) begin
      sum_d = sum_d + {{LG{bank_rd[i][CW-1]}}, bank_rd[i]};
    end
  end

  assign sum_ext = {{B{sum2_q[SW-1]}}, sum2_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      v1_q       <= 1'b0;
      s1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      s2_q       <= 1'b0;
      l2_q       <= 1'b0;
      l3_q       <= 1'b0;
      sum2_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      v1_q   <= accept;
      s1_q   <= accept && state_q == IDLE;
      l1_q   <= last_plane;
      v2_q   <= v1_q;
      s2_q   <= s1_q;
      l2_q   <= l1_q;
      l3_q   <= l2_q;
      sum2_q <= sum_d;

      // Sign plane carries weight -2^(B-1); restarting from it clears history.
      if (v2_q) begin
        if (s2_q) acc_q <= ACCW'(0) - sum_ext;
        else      acc_q <= (acc_q << 1) + sum_ext;
      end

      case (state_q)
        IDLE: if (accept) begin
          state_q <= RUN;
          cnt_q   <= CNTW'(1);
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNTW'(B - 1)) state_q <= DRAIN;
        end
        DRAIN: if (l3_q) begin
          state_q    <= HOLD;
          out_data_q <= acc_q;
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = state_q == HOLD;
  assign out_data  = out_data_q;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_da_mac_engine.sv
// Self-checking bench for da_mac_engine (NBANK=2, K=2, CW=8, B=4) against a
// weighted-sum model of the bit-plane frame.
module tb_da_mac_engine;

  localparam int NBANK = 2;
  localparam int K     = 2;
  localparam int CW    = 8;
  localparam int B     = 4;
  localparam int ACCW  = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              cload;
  logic [2:0]        caddr;
  logic [CW-1:0]     cdata;
  logic              plane_valid;
  logic              plane_ready;
  logic [NBANK*K-1:0] plane_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ACCW-1:0]   out_data;
  logic              busy;

  da_mac_engine #(.NBANK(NBANK), .K(K), .CW(CW), .B(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .cload       (cload),
    .caddr       (caddr),
    .cdata       (cdata),
    .plane_valid (plane_valid),
    .plane_ready (plane_ready),
    .plane_addr  (plane_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  int lut_m [2][4];
  int pa0 [4];
  int pa1 [4];

  logic [ACCW-1:0] d_res;
  int              d_lat;
  bit              d_stable, d_pr, d_busy, d_post, d_timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lut(input int bank, input int entry, input int value);
    cload = 1'b1;
    caddr = 3'(bank * 4 + entry);
    cdata = 8'(value);
    tick();
    cload = 1'b0;
    lut_m[bank][entry] = value;
  endtask

  // Frame value = -S0*2^(B-1) + sum_{j>0} Sj*2^(B-1-j), Sj = bank sums of plane j.
  function automatic logic [ACCW-1:0] model_frame();
    longint r;
    int     s, w;
    r = 0;
    for (int j = 0; j < B; j++) begin
      s = lut_m[0][pa0[j]] + lut_m[1][pa1[j]];
      w = 1 << (B - 1 - j);
      if (j == 0) r = r - longint'(s) * w;
      else        r = r + longint'(s) * w;
    end
    return ACCW'(r);
  endfunction

  task automatic drive_frame(input int gap_mask, input int hold,
                             input int cl_plane, input int cl_addr, input int cl_data);
    d_stable = 1; d_pr = 1; d_busy = 1; d_post = 1; d_timeout = 0; d_lat = 0;
    for (int j = 0; j < B; j++) begin
      if (gap_mask[j]) begin
        plane_valid = 1'b0;
        tick();
        if (j > 0 && !busy) d_busy = 0;
      end
      plane_valid = 1'b1;
      plane_addr  = 4'(pa1[j] * 4 + pa0[j]);
      if (j == cl_plane) begin
        cload = 1'b1;
        caddr = 3'(cl_addr);
        cdata = 8'(cl_data);
      end
      #1;
      if (!plane_ready) d_pr = 0;
      @(posedge clk);
      #1;
      cload = 1'b0;
      if (!busy) d_busy = 0;
    end
    plane_valid = 1'b0;
    while (!out_valid && d_lat < 20) begin
      if (plane_ready) d_pr = 0;
      if (!busy) d_busy = 0;
      tick();
      d_lat++;
    end
    if (!out_valid) begin
      d_timeout = 1;
      return;
    end
    d_res = out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!out_valid || out_data !== d_res) d_stable = 0;
      if (plane_ready) d_pr = 0;
      if (!busy) d_busy = 0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_valid || busy || out_data !== d_res) d_post = 0;
    frame_no++;
    $display("frame %0d: result=%0d latency=%0d hold=%0d", frame_no,
             $signed(out_data), d_lat, hold);
  endtask

  task automatic test_reset();
    reset = 1'b1; cload = 1'b0; caddr = '0; cdata = '0;
    plane_valid = 1'b1; plane_addr = '0; out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (plane_ready !== 1'b0) begin
      failures++; $display("FAIL reset_plane_ready: got %b want 0", plane_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    plane_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (plane_ready !== 1'b1) begin
      failures++; $display("FAIL idle_plane_ready: got %b want 1", plane_ready);
    end
  endtask

  task automatic test_basic();
    for (int a = 0; a < 4; a++) begin
      load_lut(0, a, 3 * a);
      load_lut(1, a, 5 * a);
    end
    for (int j = 0; j < B; j++) begin pa0[j] = 1; pa1[j] = 0; end
    drive_frame(0, 0, -1, 0, 0);
    checks++;
    if (d_timeout) begin
      failures++; $display("FAIL basic_timeout: out_valid never rose, want within 3 edges");
      return;
    end
    checks++;
    if (d_res !== 13'h1FFD) begin
      failures++; $display("FAIL basic_result: got %h want 1ffd", d_res);
    end
    checks++;
    if (d_lat != 3) begin
      failures++; $display("FAIL basic_latency: got %0d want 3", d_lat);
    end
    checks++;
    if (!d_post) begin
      failures++; $display("FAIL basic_handshake: out_valid=%b busy=%b want 0/0 after accept", out_valid, busy);
    end
  endtask

  task automatic test_sign_plane();
    pa0[0] = 0; pa1[0] = 0;
    for (int j = 1; j < B; j++) begin pa0[j] = 0; pa1[j] = 3; end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL sign_busy_idle: got %b want 0", busy);
    end
    drive_frame(0, 2, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== 13'd105) begin
      failures++; $display("FAIL sign_result: got %0d want 105 (timeout=%0d)", $signed(d_res), d_timeout);
    end
    checks++;
    if (!d_busy || !d_post) begin
      failures++; $display("FAIL sign_busy: in_frame_ok=%0d after_ok=%0d want 1/1", d_busy, d_post);
    end
  endtask

  task automatic test_negative_entry();
    load_lut(0, 1, -16);
    for (int j = 0; j < B; j++) begin pa0[j] = 0; pa1[j] = 0; end
    pa0[B-1] = 1;
    drive_frame(0, 0, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== 13'h1FF0) begin
      failures++; $display("FAIL negative_entry: got %0d want -16", $signed(d_res));
    end
    load_lut(0, 1, 3);
  endtask

  task automatic test_bubbles_backpressure();
    logic [ACCW-1:0] exp;
    for (int j = 0; j < B; j++) begin
      pa0[j] = $urandom_range(0, 3);
      pa1[j] = $urandom_range(0, 3);
    end
    exp = model_frame();
    drive_frame(4'b0110, 5, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== exp) begin
      failures++; $display("FAIL bubble_result: got %0d want %0d", $signed(d_res), $signed(exp));
    end
    checks++;
    if (!d_pr) begin
      failures++; $display("FAIL bubble_plane_ready: ready seen high in DRAIN/HOLD, want 0");
    end
    checks++;
    if (!d_stable) begin
      failures++; $display("FAIL bubble_hold_stable: out_data/out_valid changed under back-pressure, want stable %0d", $signed(exp));
    end
  endtask

  task automatic test_cload_ignored();
    logic [ACCW-1:0] exp;
    int val;
    for (int j = 0; j < B; j++) begin pa0[j] = 2; pa1[j] = j % 4; end
    exp = model_frame();
    drive_frame(0, 1, 1, 2, 77);
    checks++;
    if (d_timeout || d_res !== exp) begin
      failures++; $display("FAIL cload_run_result: got %0d want %0d", $signed(d_res), $signed(exp));
    end
    for (int j = 0; j < B; j++) begin pa0[j] = 2; pa1[j] = 0; end
    exp = model_frame();
    drive_frame(0, 0, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== exp) begin
      failures++; $display("FAIL cload_run_lut_kept: got %0d want %0d", $signed(d_res), $signed(exp));
    end
    val = $urandom_range(1, 100) - 50;
    plane_valid = 1'b1;
    plane_addr  = '0;
    cload = 1'b1; caddr = 3'd6; cdata = 8'(val);
    #1;
    checks++;
    if (plane_ready !== 1'b0) begin
      failures++; $display("FAIL cload_idle_ready: got %b want 0", plane_ready);
    end
    @(posedge clk); #1;
    cload = 1'b0; plane_valid = 1'b0;
    lut_m[1][2] = val;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL cload_idle_no_accept: busy=%b want 0", busy);
    end
    for (int j = 0; j < B; j++) begin pa0[j] = 1; pa1[j] = 2; end
    pa1[0] = 0;
    exp = model_frame();
    drive_frame(0, 0, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== exp) begin
      failures++; $display("FAIL cload_idle_write: got %0d want %0d", $signed(d_res), $signed(exp));
    end
  endtask

  task automatic test_async_reset();
    logic [ACCW-1:0] exp;
    for (int j = 0; j < 2; j++) begin
      plane_valid = 1'b1;
      plane_addr  = 4'(j * 5 + 3);
      tick();
    end
    plane_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || plane_ready !== 1'b0) begin
      failures++; $display("FAIL async_reset_flags: out_valid=%b busy=%b plane_ready=%b want 0/0/0",
                           out_valid, busy, plane_ready);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL async_reset_out_data: got %h want 0", out_data);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int j = 0; j < B; j++) begin
      pa0[j] = $urandom_range(0, 3);
      pa1[j] = $urandom_range(0, 3);
    end
    exp = model_frame();
    drive_frame(0, 0, -1, 0, 0);
    checks++;
    if (d_timeout || d_res !== exp) begin
      failures++; $display("FAIL async_reset_fresh: got %0d want %0d", $signed(d_res), $signed(exp));
    end
    checks++;
    if (d_lat != 3) begin
      failures++; $display("FAIL async_reset_latency: got %0d want 3", d_lat);
    end
  endtask

  task automatic test_random();
    logic [ACCW-1:0] exp;
    for (int f = 0; f < 8; f++) begin
      for (int n = 0; n < 3; n++) begin
        load_lut($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255) - 128);
      end
      for (int j = 0; j < B; j++) begin
        pa0[j] = $urandom_range(0, 3);
        pa1[j] = $urandom_range(0, 3);
      end
      exp = model_frame();
      drive_frame($urandom_range(0, 15), $urandom_range(0, 3), -1, 0, 0);
      checks++;
      if (d_timeout || d_res !== exp || !d_stable || !d_pr || !d_post) begin
        failures++;
        $display("FAIL random_frame_%0d: got %0d want %0d (timeout=%0d stable=%0d ready_ok=%0d post=%0d)",
                 f, $signed(d_res), $signed(exp), d_timeout, d_stable, d_pr, d_post);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_plane();
    test_negative_entry();
    test_bubbles_backpressure();
    test_cload_ignored();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
